// File: rtl/motor_ctrl_pkg.sv
// Shared types for the motor control slice: throttle width, sequencer
// states and the slew-limited ramp step used on every frame tick.
package motor_ctrl_pkg;

  localparam int THROTTLE_W = 15;

  typedef logic [THROTTLE_W-1:0] throttle_t;

  typedef enum logic [1:0] {
    DISARMED    = 2'd0,
    ARMING      = 2'd1,
    ARMED       = 2'd2,
    MODE_SWITCH = 2'd3
  } seq_state_t;

  // One slew-limited move from cur toward tgt. The arithmetic is 16-bit so
  // cur + step cannot wrap, and a move of at most step lands exactly on tgt,
  // so the result can neither overshoot nor wrap.
  function automatic throttle_t ramp_toward(input throttle_t   cur,
                                            input throttle_t   tgt,
                                            input logic [15:0] step);
    logic [15:0] c16;
    logic [15:0] t16;
    logic [15:0] diff;
    logic [15:0] res;
    c16 = {1'b0, cur};
    t16 = {1'b0, tgt};
    if (t16 >= c16) begin
      diff = t16 - c16;
      res  = (diff <= step) ? t16 : c16 + step;
    end else begin
      diff = c16 - t16;
      res  = (diff <= step) ? t16 : c16 - step;
    end
    return THROTTLE_W'(res);
  endfunction

endpackage

// File: rtl/throttle_sequencer_if.sv
// Host command channel into the throttle sequencer (valid/ready handshake).
interface throttle_sequencer_if;
  import motor_ctrl_pkg::*;

  logic      cmd_valid_i;
  logic      cmd_ready_o;
  throttle_t cmd_throttle_i;
  logic      cmd_is_digital_i;

  modport master (
    output cmd_valid_i,
    output cmd_throttle_i,
    output cmd_is_digital_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_throttle_i,
    input  cmd_is_digital_i,
    output cmd_ready_o
  );

endinterface

// File: rtl/frame_timer.sv
// Free-running frame counter 0..FRAME_CYCLES-1 with a registered one-cycle
// strobe that is high while the count sits at FRAME_CYCLES-1.
module frame_timer #(
  parameter int FRAME_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic nreset_i,
  output logic tick_o
);

  localparam int            CW       = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST     = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(FRAME_CYCLES - 2);

  logic [CW-1:0] cnt_q;

  // Count continuously; the strobe is set one cycle early so it is a flop.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_o <= (cnt_q == PRE_LAST);
    end
  end

endmodule

// File: rtl/throttle_sequencer.sv
// Arming, slew limiting, mode switching and command watchdog in front of
// the PWM generator. Throttle and mode only move on frame ticks (except the
// immediate zeroing on disarm and mode loads while disarmed).
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   DISARMED    | output forced to 0; commands only set the output mode
//   ARMING      | zero throttle held while ARM_FRAMES ticks are counted
//   ARMED       | commands set the target; ramp and watchdog run per tick
//   MODE_SWITCH | ramping to 0, then apply pending mode and re-arm
module throttle_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int FRAME_CYCLES   = 50000,
  parameter int ARM_FRAMES     = 20,
  parameter int RAMP_STEP      = 256,
  parameter int TIMEOUT_FRAMES = 100
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 arm_i,
  throttle_sequencer_if.slave  cmd,
  output throttle_t            throttle_o,
  output logic                 is_digital_o,
  output logic                 armed_o,
  output logic                 failsafe_o,
  output logic                 frame_tick_o
);

  localparam int            AW       = $clog2(ARM_FRAMES + 1);
  localparam int            WW       = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_FRAMES);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_FRAMES);
  localparam logic [15:0]   STEP16   = 16'(RAMP_STEP);

  seq_state_t    state_q, state_d;
  throttle_t     target_q, target_d;
  throttle_t     throttle_d;
  logic          pend_q, pend_d;
  logic          mode_d;
  logic          failsafe_d;
  logic          armed_d;
  logic          ready_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic          tick;
  logic          accept;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .tick_o   (tick)
  );

  assign frame_tick_o = tick;

  // Next-state and datapath: disarm overrides everything, then per-state work.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    throttle_d = throttle_o;
    pend_d     = pend_q;
    mode_d     = is_digital_o;
    failsafe_d = failsafe_o;
    arm_cnt_d  = arm_cnt_q;
    wd_d       = wd_q;
    accept     = cmd.cmd_valid_i && cmd.cmd_ready_o;
    wd_inc     = (wd_q == WD_LAST) ? wd_q : wd_q + WW'(1);

    if (state_q != DISARMED && !arm_i) begin
      state_d    = DISARMED;
      throttle_d = '0;
      failsafe_d = 1'b0;
    end else begin
      case (state_q)
        DISARMED: begin
          throttle_d = '0;
          if (accept) mode_d = cmd.cmd_is_digital_i;
          if (arm_i) begin
            state_d   = ARMING;
            arm_cnt_d = '0;
          end
        end

        ARMING: begin
          if (tick) begin
            arm_cnt_d = arm_cnt_q + AW'(1);
            if (arm_cnt_d == ARM_LAST) begin
              state_d  = ARMED;
              target_d = '0;
              wd_d     = '0;
            end
          end
        end

        ARMED: begin
          // An accepted command restarts the watchdog, so it wins over a
          // watchdog expiry falling in the same tick cycle.
          if (accept) begin
            wd_d = '0;
            if (cmd.cmd_is_digital_i == is_digital_o) begin
              target_d   = cmd.cmd_throttle_i;
              failsafe_d = 1'b0;
            end else begin
              pend_d   = cmd.cmd_is_digital_i;
              target_d = '0;
              state_d  = MODE_SWITCH;
            end
          end else if (tick) begin
            wd_d = wd_inc;
            if (wd_inc == WD_LAST) begin
              failsafe_d = 1'b1;
              target_d   = '0;
            end
          end
          if (tick) throttle_d = ramp_toward(throttle_o, target_d, STEP16);
        end

        MODE_SWITCH: begin
          if (tick) begin
            if (throttle_o == '0) begin
              mode_d    = pend_q;
              state_d   = ARMING;
              arm_cnt_d = '0;
            end else begin
              throttle_d = ramp_toward(throttle_o, target_q, STEP16);
            end
          end
        end

        default: begin
          state_d    = DISARMED;
          throttle_d = '0;
        end
      endcase
    end

    ready_d = (state_d == DISARMED) || (state_d == ARMED);
    armed_d = (state_d == ARMED);
  end

  // State, datapath and output registers; reset lands in DISARMED.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q         <= DISARMED;
      target_q        <= '0;
      pend_q          <= 1'b0;
      arm_cnt_q       <= '0;
      wd_q            <= '0;
      throttle_o      <= '0;
      is_digital_o    <= 1'b0;
      failsafe_o      <= 1'b0;
      armed_o         <= 1'b0;
      cmd.cmd_ready_o <= 1'b1;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      pend_q          <= pend_d;
      arm_cnt_q       <= arm_cnt_d;
      wd_q            <= wd_d;
      throttle_o      <= throttle_d;
      is_digital_o    <= mode_d;
      failsafe_o      <= failsafe_d;
      armed_o         <= armed_d;
      cmd.cmd_ready_o <= ready_d;
    end
  end

endmodule
